// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: drains every register-file entry through one read port
// and streams (addr, data) pairs on a valid/ready interface, with write-bypass.
`default_nettype none

module regfile_dump_reader #(
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  input  logic          snoop_we,
  input  logic [AW-1:0] snoop_addr,
  input  logic [DW-1:0] snoop_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // A write landing on the entry being fetched wins over the stale read data.
  logic bypass;
  assign bypass = snoop_we && (snoop_addr == rd_addr_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          idx_d     = '0;
          rd_addr_d = '0;
          busy_d    = 1'b1;
        end
      end
      FETCH: begin
        out_data_d  = bypass ? snoop_data : rd_data;
        out_addr_d  = rd_addr_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_q + 1'b1;
            rd_addr_d = idx_q + 1'b1;
            state_d   = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a small 4x8 register-file model.
`default_nettype none

module tb_regfile_dump_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       snoop_we = 1'b0;
  logic [1:0] snoop_addr = 2'd0;
  logic [7:0] snoop_data = 8'd0;
  logic       out_ready = 1'b0;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_addr;
  logic       busy;
  logic       done;

  logic [7:0] rf [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Register file: synchronous write through the snooped port, async read.
  always @(posedge clk) if (snoop_we) rf[snoop_addr] <= snoop_data;
  assign rd_data = rf[rd_addr];

  regfile_dump_reader #(.NREG(4), .AW(2), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .snoop_we   (snoop_we),
    .snoop_addr (snoop_addr),
    .snoop_data (snoop_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_rf(input logic [1:0] a, input logic [7:0] d);
    snoop_we = 1'b1; snoop_addr = a; snoop_data = d;
    @(negedge clk);
    snoop_we = 1'b0;
  endtask

  task automatic set_snoop(input int k, input logic [7:0] d);
    snoop_we = 1'b1; snoop_addr = k[1:0]; snoop_data = d;
  endtask

  // One full dump. stall = cycles out_ready stays low per entry (0 = always ready).
  // wr_k/wr_fetch/wr_val inject one register write during FETCH or SEND of entry wr_k.
  task automatic dump(input int stall, input logic hold_start, input int wr_k,
                      input logic wr_fetch, input logic [7:0] wr_val,
                      input logic [3:0][7:0] e);
    out_ready = (stall == 0);
    start = 1'b1;
    @(negedge clk);
    chk("accept_busy", 32'(busy), 32'd1);
    chk("fetch0_valid", 32'(out_valid), 32'd0);
    start = hold_start;
    if (wr_fetch && wr_k == 0) set_snoop(0, wr_val);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      snoop_we = 1'b0;
      chk("send_valid", 32'(out_valid), 32'd1);
      chk("send_addr", 32'(out_addr), 32'(k));
      chk("send_data", 32'(out_data), 32'(e[k]));
      chk("send_busy", 32'(busy), 32'd1);
      if (!wr_fetch && wr_k == k) set_snoop(k, wr_val);
      for (int s = 1; s < stall; s++) begin
        @(negedge clk);
        snoop_we = 1'b0;
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_addr", 32'(out_addr), 32'(k));
        chk("stall_data", 32'(out_data), 32'(e[k]));
        chk("stall_done", 32'(done), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      snoop_we = 1'b0;
      chk("accepted_valid", 32'(out_valid), 32'd0);
      out_ready = (stall == 0);
      if (k < 3) begin
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_done", 32'(done), 32'd0);
        if (wr_fetch && wr_k == k + 1) set_snoop(k + 1, wr_val);
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
      end
    end
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("no_restart_busy", 32'(busy), 32'd0);
    chk("no_restart_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    write_rf(2'd0, 8'hAA);
    write_rf(2'd1, 8'hFF);
    write_rf(2'd2, 8'h11);
    write_rf(2'd3, 8'hAB);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy0", 32'(busy), 32'd0);

    // Back-to-back streaming, then 5-cycle stall per entry.
    dump(0, 1'b0, -1, 1'b0, 8'h00, {8'hAB, 8'h11, 8'hFF, 8'hAA});
    dump(5, 1'b0, -1, 1'b0, 8'h00, {8'hAB, 8'h11, 8'hFF, 8'hAA});

    // Write to R2 during its FETCH is bypassed into the stream.
    dump(0, 1'b0, 2, 1'b1, 8'h5C, {8'hAB, 8'h5C, 8'hFF, 8'hAA});
    chk("rf_bypass_written", 32'(rf[2]), 32'h5C);
    write_rf(2'd2, 8'h11);

    // Write to R2 during its SEND must not disturb the held snapshot.
    dump(3, 1'b0, 2, 1'b0, 8'h77, {8'hAB, 8'h11, 8'hFF, 8'hAA});
    chk("rf_send_written", 32'(rf[2]), 32'h77);
    write_rf(2'd2, 8'h11);

    // start held high throughout: no restart, one done pulse.
    dump(0, 1'b1, -1, 1'b0, 8'h00, {8'hAB, 8'h11, 8'hFF, 8'hAA});

    // Asynchronous reset while R1 is in SEND.
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_r0", 32'(out_data), 32'hAA);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_r1_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_r1_addr", 32'(out_addr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dump(0, 1'b0, -1, 1'b0, 8'h00, {8'hAB, 8'h11, 8'hFF, 8'hAA});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
